// File: rtl/file_job_scheduler.sv
// Round-robin scheduler sharing one file-processing engine among NREQ requesters.
// Issues one job at a time, watches for completion with a watchdog, reports done/error.
module file_job_scheduler #(
  parameter int NREQ    = 4,
  parameter int IDX_W   = 10,
  parameter int TIMEOUT = 4096,
  localparam int OW     = (NREQ > 1) ? $clog2(NREQ) : 1,
  localparam int TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*IDX_W-1:0]  req_index,
  output logic [NREQ-1:0]        grant,
  output logic [NREQ-1:0]        done,
  output logic [NREQ-1:0]        error,
  output logic                   busy,
  output logic [OW-1:0]          owner,
  output logic                   eng_start,
  output logic [IDX_W-1:0]       eng_file_index,
  input  logic                   eng_finish
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_START   = 2'd1,
    S_WAIT    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [OW-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [TW-1:0]    timer_q, timer_d;
  logic             finish_q, finish_d;
  logic [NREQ-1:0]  grant_q, grant_d;
  logic [NREQ-1:0]  done_q, done_d;
  logic [NREQ-1:0]  error_q, error_d;
  logic             eng_start_q, eng_start_d;
  logic             busy_q, busy_d;
  logic [OW-1:0]    pick_s;
  logic             finish_rise_s;

  // First set request bit scanning from ptr upwards, wrapping mod NREQ.
  function automatic logic [OW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] ptr);
    logic [OW-1:0] sel;
    logic [OW-1:0] pos;
    logic          found;
    int            j;
    sel   = '0;
    found = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      if (j >= NREQ) begin
        j = j - NREQ;
      end else begin
        j = j;
      end
      pos = OW'(j);
      if (!found && r[pos]) begin
        found = 1'b1;
        sel   = pos;
      end else begin
        found = found;
      end
    end
    return sel;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input logic [OW-1:0] i);
    logic [NREQ-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  assign pick_s        = rr_pick(req, rr_ptr_q);
  assign finish_rise_s = eng_finish && !finish_q;

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      idx_q       <= '0;
      timer_q     <= '0;
      finish_q    <= 1'b0;
      grant_q     <= '0;
      done_q      <= '0;
      error_q     <= '0;
      eng_start_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      finish_q    <= finish_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      error_q     <= error_d;
      eng_start_q <= eng_start_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and next-output logic; pulses default low, context holds.
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    owner_d     = owner_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    finish_d    = eng_finish;
    grant_d     = '0;
    done_d      = '0;
    error_d     = '0;
    eng_start_d = 1'b0;
    busy_d      = busy_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          state_d     = S_START;
          owner_d     = pick_s;
          idx_d       = req_index[int'(pick_s)*IDX_W +: IDX_W];
          grant_d     = onehot(pick_s);
          eng_start_d = 1'b1;
          busy_d      = 1'b1;
        end else begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end
      end
      S_START: begin
        state_d = S_WAIT;
        timer_d = '0;
        busy_d  = 1'b1;
      end
      S_WAIT: begin
        busy_d = 1'b1;
        // A finish level already present on entry never produces a rising edge here.
        if (finish_rise_s) begin
          state_d = S_RELEASE;
          done_d  = onehot(owner_q);
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          state_d = S_RELEASE;
          error_d = onehot(owner_q);
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_RELEASE: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
        if (owner_q == OW'(NREQ - 1)) begin
          rr_ptr_d = '0;
        end else begin
          rr_ptr_d = owner_q + OW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  assign grant          = grant_q;
  assign done           = done_q;
  assign error          = error_q;
  assign busy           = busy_q;
  assign owner          = owner_q;
  assign eng_start      = eng_start_q;
  assign eng_file_index = idx_q;

endmodule

// File: tb/tb_file_job_scheduler.sv
// Bench for file_job_scheduler: job table with a scoreboard of expected grant/done events,
// plus hand sequences for reset, stale finish, mid-job reset and the watchdog.
module tb_file_job_scheduler;

  localparam int NREQ     = 4;
  localparam int IDX_W    = 10;
  localparam int TO_LONG  = 128;
  localparam int TO_SHORT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [39:0] req_index;
  logic        eng_finish;

  logic [3:0]  grant, done, error;
  logic        busy, eng_start;
  logic [1:0]  owner;
  logic [9:0]  eng_file_index;

  logic [3:0]  grant_t, done_t, error_t;
  logic        busy_t, eng_start_t;
  logic [1:0]  owner_t;
  logic [9:0]  eng_file_index_t;

  file_job_scheduler #(.NREQ(NREQ), .IDX_W(IDX_W), .TIMEOUT(TO_LONG)) dut (
    .clk(clk), .rst(rst), .req(req), .req_index(req_index),
    .grant(grant), .done(done), .error(error), .busy(busy), .owner(owner),
    .eng_start(eng_start), .eng_file_index(eng_file_index), .eng_finish(eng_finish)
  );

  file_job_scheduler #(.NREQ(NREQ), .IDX_W(IDX_W), .TIMEOUT(TO_SHORT)) dut_to (
    .clk(clk), .rst(rst), .req(req), .req_index(req_index),
    .grant(grant_t), .done(done_t), .error(error_t), .busy(busy_t), .owner(owner_t),
    .eng_start(eng_start_t), .eng_file_index(eng_file_index_t), .eng_finish(eng_finish)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] g;
    logic [3:0] d;
    logic [3:0] e;
    logic [9:0] idx;
  } ev_t;

  typedef struct {
    logic [3:0] rq;
    logic [9:0] base;
    int         dly;
    bit         hold;
    logic [3:0] exp_g;
  } job_t;

  ev_t  exp_q[$];
  job_t jobs[13];
  int   n_total = 0;
  int   n_pass  = 0;
  bit   mon_en  = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic int idx_of(input logic [3:0] v);
    int r;
    r = 0;
    for (int i = 0; i < 4; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic logic [39:0] fill_idx(input logic [9:0] base);
    logic [39:0] r;
    for (int i = 0; i < 4; i++) r[i*10 +: 10] = base + 10'(i);
    return r;
  endfunction

  task automatic push_ev(input logic [3:0] g, input logic [3:0] d, input logic [9:0] idx);
    ev_t e;
    e.g = g; e.d = d; e.e = 4'b0000; e.idx = idx;
    exp_q.push_back(e);
  endtask

  // Scoreboard: every grant/done/error pulse of the main DUT must match the next expectation.
  always @(negedge clk) begin : monitor
    ev_t e;
    if (mon_en && ((grant | done | error) != 4'b0000)) begin
      if (exp_q.size() == 0) begin
        check("unexpected_event", {grant, done, error}, 12'h000);
      end else begin
        e = exp_q.pop_front();
        check("event", {grant, done, error}, {e.g, e.d, e.e});
        if (e.g != 4'b0000) begin
          check("start_pulse", eng_start, 1'b1);
          check("start_index", eng_file_index, e.idx);
        end
      end
    end
  end

  task automatic run_job(input job_t j);
    bit         started;
    int         own;
    logic [9:0] xi;
    own       = idx_of(j.exp_g);
    xi        = j.base + 10'(own);
    req       = j.rq;
    req_index = fill_idx(j.base);
    push_ev(j.exp_g, 4'b0000, xi);
    push_ev(4'b0000, j.exp_g, 10'd0);
    started = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (eng_start) begin
        started = 1'b1;
        break;
      end
    end
    check("job_start", started, 1'b1);
    if (!started) return;
    check("owner", owner, own);
    check("busy_start", busy, 1'b1);
    if (!j.hold) req = 4'b0000;
    req_index = '1;
    repeat (j.dly - 1) tick();
    eng_finish = 1'b1;
    tick();
    eng_finish = 1'b0;
    check("release_busy", busy, 1'b1);
    check("held_index", eng_file_index, xi);
    tick();
    check("idle_busy", busy, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit started;
    jobs[0]  = '{4'b1111, 10'd100, 3,  1'b1, 4'b0001};
    jobs[1]  = '{4'b1111, 10'd110, 3,  1'b1, 4'b0010};
    jobs[2]  = '{4'b1111, 10'd120, 3,  1'b1, 4'b0100};
    jobs[3]  = '{4'b1111, 10'd130, 3,  1'b1, 4'b1000};
    jobs[4]  = '{4'b1111, 10'd140, 3,  1'b1, 4'b0001};
    jobs[5]  = '{4'b1010, 10'd150, 3,  1'b1, 4'b0010};
    jobs[6]  = '{4'b1010, 10'd160, 3,  1'b1, 4'b1000};
    jobs[7]  = '{4'b1010, 10'd170, 3,  1'b0, 4'b0010};
    jobs[8]  = '{4'b0001, 10'd5,   70, 1'b0, 4'b0001};
    jobs[9]  = '{4'b0110, 10'd180, 4,  1'b0, 4'b0010};
    jobs[10] = '{4'b1100, 10'd190, 2,  1'b0, 4'b0100};
    jobs[11] = '{4'b0011, 10'd200, 5,  1'b0, 4'b0001};
    jobs[12] = '{4'b0101, 10'd210, 3,  1'b0, 4'b0100};

    // Reset held with all requests pending.
    rst = 1'b0; req = 4'b1111; req_index = fill_idx(10'd20); eng_finish = 1'b0;
    mon_en = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("reset_outputs", {grant, done, error, eng_start, busy, owner, eng_file_index}, 26'd0);
    end
    check("reset_outputs_to", {grant_t, done_t, error_t, eng_start_t, busy_t, owner_t, eng_file_index_t}, 26'd0);
    push_ev(4'b0001, 4'b0000, 10'd20);
    push_ev(4'b0000, 4'b0001, 10'd0);
    rst = 1'b1;
    tick();
    check("grant_after_reset", {grant, eng_start}, {4'b0001, 1'b1});
    req = 4'b0000;
    repeat (2) tick();
    eng_finish = 1'b1;
    tick();
    eng_finish = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("reset_outputs", {grant, done, error, eng_start, busy, owner, eng_file_index}, 26'd0);
    rst = 1'b1;

    // Fairness, single long job and assorted pointer positions.
    for (int k = 0; k < 13; k++) run_job(jobs[k]);

    // Reset in the middle of WAIT: no outcome, pointer back to 0, stray finish ignored.
    req = 4'b1000; req_index = fill_idx(10'd300);
    push_ev(4'b1000, 4'b0000, 10'd303);
    started = 1'b0;
    for (int t = 0; t < 8; t++) begin
      tick();
      if (eng_start) begin
        started = 1'b1;
        break;
      end
    end
    check("abort_job_start", started, 1'b1);
    req = 4'b0000;
    repeat (10) tick();
    check("abort_busy_wait", busy, 1'b1);
    rst = 1'b0;
    tick();
    check("abort_reset_outputs", {grant, done, error, eng_start, busy, owner, eng_file_index}, 26'd0);
    rst = 1'b1;
    eng_finish = 1'b1;
    tick();
    eng_finish = 1'b0;
    repeat (3) tick();
    check("abort_idle", busy, 1'b0);
    run_job('{4'b1010, 10'd310, 4, 1'b0, 4'b0010});

    // Finish level already high across start is stale until it falls and rises again.
    eng_finish = 1'b1;
    req = 4'b0001; req_index = fill_idx(10'd400);
    push_ev(4'b0001, 4'b0000, 10'd400);
    push_ev(4'b0000, 4'b0001, 10'd0);
    tick();
    check("stale_start", eng_start, 1'b1);
    req = 4'b0000;
    for (int t = 0; t < 6; t++) begin
      tick();
      check("stale_no_done", {done, busy}, {4'b0000, 1'b1});
    end
    eng_finish = 1'b0;
    repeat (2) tick();
    check("stale_low_no_done", {done, busy}, {4'b0000, 1'b1});
    eng_finish = 1'b1;
    tick();
    check("stale_done", done, 4'b0001);
    repeat (3) tick();
    eng_finish = 1'b0;
    tick();
    check("stale_idle", busy, 1'b0);

    check("scoreboard_drained", exp_q.size(), 0);
    mon_en = 1'b0;

    // Watchdog on the short-timeout instance.
    rst = 1'b0;
    tick();
    rst = 1'b1; req = 4'b0100; req_index = fill_idx(10'd500);
    tick();
    check("to_grant", {grant_t, eng_start_t, eng_file_index_t}, {4'b0100, 1'b1, 10'd502});
    req = 4'b0000;
    for (int w = 1; w <= TO_SHORT; w++) begin
      tick();
      check("to_waiting", {error_t, done_t, busy_t}, {4'b0000, 4'b0000, 1'b1});
      if (w == 8) begin
        req = 4'b1001;
        req_index = fill_idx(10'd510);
      end
    end
    tick();
    check("to_error", {error_t, done_t, busy_t}, {4'b0100, 4'b0000, 1'b1});
    tick();
    check("to_idle", {error_t, busy_t}, {4'b0000, 1'b0});
    tick();
    check("to_next_grant", {grant_t, eng_file_index_t}, {4'b1000, 10'd513});
    req = 4'b0000;
    repeat (TO_SHORT) tick();
    eng_finish = 1'b1;
    tick();
    check("to_finish_wins", {done_t, error_t}, {4'b1000, 4'b0000});
    eng_finish = 1'b0;
    tick();
    check("to_final_idle", busy_t, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
